// File: rtl/ext_mem_controller_pkg.sv
// Shared types for the external memory controller: FSM states, op codes,
// and a small elaboration-time helper.
package ext_mem_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ext_mem_controller_if.sv
// Request/response bus between memory_system and the external memory target.
interface ext_mem_controller_if #(
    parameter int unsigned WORD_SIZE = 32
) ();

    logic [31:0]          mem_addr;
    logic                 en_ext_mem_re;
    logic                 en_ext_mem_wr;
    logic [WORD_SIZE-1:0] wr_data;
    logic [WORD_SIZE-1:0] rd_data;
    logic                 mem_ready;
    logic                 addr_err;

    modport master (
        output mem_addr, en_ext_mem_re, en_ext_mem_wr, wr_data,
        input  rd_data, mem_ready, addr_err
    );

    modport slave (
        input  mem_addr, en_ext_mem_re, en_ext_mem_wr, wr_data,
        output rd_data, mem_ready, addr_err
    );

endinterface

// File: rtl/ext_mem_controller_sp_ram.sv
// Single-port synchronous RAM with write enable and registered read port.
module sp_ram #(
    parameter int unsigned WORD_SIZE  = 32,
    parameter int unsigned DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic                  re,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [WORD_SIZE-1:0]  wdata,
    output logic [WORD_SIZE-1:0]  rdata
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    logic [WORD_SIZE-1:0] mem_q [DEPTH];
    logic [WORD_SIZE-1:0] rdata_q;

    // Write port and registered read port share the single address.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/ext_mem_controller.sv
// Latency-modelled external memory target: one word access per request,
// one-cycle mem_ready pulse after a programmable latency, RAM window at BASE_ADDR.
module ext_mem_controller
    import ext_mem_controller_pkg::*;
#(
    parameter int unsigned WORD_SIZE     = 32,
    parameter int unsigned DEPTH_LOG2    = 10,
    parameter logic [31:0] BASE_ADDR     = 32'h0,
    parameter int unsigned READ_LATENCY  = 4,
    parameter int unsigned WRITE_LATENCY = 2
) (
    input logic                 clk,
    input logic                 rst,
    ext_mem_controller_if.slave bus
);

    localparam int unsigned MAX_LAT  = max_u(READ_LATENCY, WRITE_LATENCY);
    localparam int unsigned CNT_W    = $clog2(MAX_LAT + 1);
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_LATENCY - 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_LATENCY - 1);
    localparam logic [32:0]      WIN_SIZE = 33'd4 << DEPTH_LOG2;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    op_e                   op_q, op_d;
    logic [DEPTH_LOG2-1:0] idx_q, idx_d;
    logic                  in_win_q, in_win_d;
    logic [WORD_SIZE-1:0]  wdata_q, wdata_d;
    logic                  mem_ready_q, mem_ready_d;
    logic [WORD_SIZE-1:0]  rd_data_q, rd_data_d;
    logic                  addr_err_q, addr_err_d;

    logic                  req;
    logic [32:0]           live_off;
    logic                  live_in_win;
    logic [DEPTH_LOG2-1:0] live_idx;

    logic                  ram_we, ram_re;
    logic [DEPTH_LOG2-1:0] ram_addr;
    logic [WORD_SIZE-1:0]  ram_rdata;

    // An address below BASE_ADDR borrows into bit 32, so one unsigned compare covers both bounds.
    assign req         = bus.en_ext_mem_re | bus.en_ext_mem_wr;
    assign live_off    = {1'b0, bus.mem_addr} - {1'b0, BASE_ADDR};
    assign live_in_win = live_off < WIN_SIZE;
    assign live_idx    = DEPTH_LOG2'(live_off >> 2);

    sp_ram #(
        .WORD_SIZE  (WORD_SIZE),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we & ~rst),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    // Next-state logic; the RAM read is launched one cycle before the
    // completion edge so its registered output lines up with mem_ready.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        idx_d       = idx_q;
        in_win_d    = in_win_q;
        wdata_d     = wdata_q;
        mem_ready_d = 1'b0;
        rd_data_d   = '0;
        addr_err_d  = 1'b0;
        ram_we      = 1'b0;
        ram_re      = 1'b0;
        ram_addr    = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d  = ST_BUSY;
                    op_d     = bus.en_ext_mem_wr ? OP_WRITE : OP_READ;
                    idx_d    = live_idx;
                    in_win_d = live_in_win;
                    wdata_d  = bus.wr_data;
                    cnt_d    = bus.en_ext_mem_wr ? WR_LOAD : RD_LOAD;
                    if (!bus.en_ext_mem_wr && READ_LATENCY == 1) begin
                        ram_re   = 1'b1;
                        ram_addr = live_idx;
                    end
                end
            end
            ST_BUSY: begin
                if (!req) begin
                    state_d = ST_IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1) && op_q == OP_READ) begin
                        ram_re = 1'b1;
                    end
                end else begin
                    state_d     = ST_DONE;
                    mem_ready_d = 1'b1;
                    addr_err_d  = ~in_win_q;
                    if (op_q == OP_WRITE) begin
                        ram_we = in_win_q;
                    end else if (in_win_q) begin
                        rd_data_d = ram_rdata;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; RAM contents survive reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            op_q        <= OP_READ;
            idx_q       <= '0;
            in_win_q    <= 1'b0;
            wdata_q     <= '0;
            mem_ready_q <= 1'b0;
            rd_data_q   <= '0;
            addr_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            idx_q       <= idx_d;
            in_win_q    <= in_win_d;
            wdata_q     <= wdata_d;
            mem_ready_q <= mem_ready_d;
            rd_data_q   <= rd_data_d;
            addr_err_q  <= addr_err_d;
        end
    end

    assign bus.rd_data   = rd_data_q;
    assign bus.mem_ready = mem_ready_q;
    assign bus.addr_err  = addr_err_q;

endmodule
